// File: rtl/axi4_lite_master.sv
// axi4_lite_master: turns one-cycle AMCI read/write strobes into single AXI4-Lite
// transactions; read and write engines are independent, one outstanding each.
module axi4_lite_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int ALIGN = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] AMCI_WADDR,
   input  logic [31:0]           AMCI_WDATA,
   input  logic                  AMCI_WRITE,
   output logic [1:0]            AMCI_WRESP,
   output logic                  AMCI_WIDLE,
   input  logic [ADDR_WIDTH-1:0] AMCI_RADDR,
   input  logic                  AMCI_READ,
   output logic [31:0]           AMCI_RDATA,
   output logic [1:0]            AMCI_RRESP,
   output logic                  AMCI_RIDLE,
   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic                  M_AXI_AWVALID,
   output logic [2:0]            M_AXI_AWPROT,
   input  logic                  M_AXI_AWREADY,
   output logic [31:0]           M_AXI_WDATA,
   output logic [3:0]            M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                  M_AXI_ARVALID,
   output logic [2:0]            M_AXI_ARPROT,
   input  logic                  M_AXI_ARREADY,
   input  logic [31:0]           M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_WAIT_B} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_SEND_AR, R_WAIT_R} rstate_t;
   localparam logic [ADDR_WIDTH-1:0] amask = (ALIGN != 0) ? {{(ADDR_WIDTH-2){1'b1}}, 2'b00} : '1;
   wstate_t wstate;
   rstate_t rstate;
   logic aw_done, w_done;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_WSTRB = 4'hF;
   assign AMCI_WIDLE = !AMCI_WRITE && wstate == W_IDLE;
   assign AMCI_RIDLE = !AMCI_READ && rstate == R_IDLE;
   // a channel counts as done if already handshaken or handshaking on this edge
   assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
   assign w_done = !M_AXI_WVALID || M_AXI_WREADY;
   always_ff @(posedge clk) begin
      if (reset) begin
         wstate <= W_IDLE;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID <= 1'b0;
         M_AXI_BREADY <= 1'b0;
         M_AXI_AWADDR <= '0;
         M_AXI_WDATA <= '0;
         AMCI_WRESP <= 2'b00;
      end else begin
         case (wstate)
            W_IDLE: if (AMCI_WRITE) begin
               M_AXI_AWADDR <= AMCI_WADDR & amask;
               M_AXI_WDATA <= AMCI_WDATA;
               M_AXI_AWVALID <= 1'b1;
               M_AXI_WVALID <= 1'b1;
               wstate <= W_SEND;
            end
            W_SEND: begin
               if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
               if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
               if (aw_done && w_done) begin
                  M_AXI_BREADY <= 1'b1;
                  wstate <= W_WAIT_B;
               end
            end
            W_WAIT_B: if (M_AXI_BVALID) begin
               AMCI_WRESP <= M_AXI_BRESP;
               M_AXI_BREADY <= 1'b0;
               wstate <= W_IDLE;
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rstate <= R_IDLE;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY <= 1'b0;
         M_AXI_ARADDR <= '0;
         AMCI_RDATA <= '0;
         AMCI_RRESP <= 2'b00;
      end else begin
         case (rstate)
            R_IDLE: if (AMCI_READ) begin
               M_AXI_ARADDR <= AMCI_RADDR & amask;
               M_AXI_ARVALID <= 1'b1;
               rstate <= R_SEND_AR;
            end
            R_SEND_AR: if (M_AXI_ARREADY) begin
               M_AXI_ARVALID <= 1'b0;
               M_AXI_RREADY <= 1'b1;
               rstate <= R_WAIT_R;
            end
            R_WAIT_R: if (M_AXI_RVALID) begin
               AMCI_RDATA <= M_AXI_RDATA;
               AMCI_RRESP <= M_AXI_RRESP;
               M_AXI_RREADY <= 1'b0;
               rstate <= R_IDLE;
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed bench with a configurable-latency AXI-Lite slave
// and a valid/ready protocol watcher acting on the falling clock edge.
module tb_axi4_lite_master;
   logic clk = 1'b0, reset = 1'b1;
   logic [31:0] AMCI_WADDR = '0, AMCI_WDATA = '0, AMCI_RADDR = '0, AMCI_RDATA;
   logic AMCI_WRITE = 1'b0, AMCI_READ = 1'b0, AMCI_WIDLE, AMCI_RIDLE;
   logic [1:0] AMCI_WRESP, AMCI_RRESP;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
   logic [31:0] M_AXI_RDATA = '0;
   logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0] M_AXI_WSTRB;
   logic M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
   logic M_AXI_AWREADY = 0, M_AXI_WREADY = 0, M_AXI_BVALID = 0, M_AXI_ARREADY = 0, M_AXI_RVALID = 0;
   logic [1:0] M_AXI_BRESP = '0, M_AXI_RRESP = '0;
   int checks = 0, errors = 0;
   int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0] bresp = 0, rresp = 0;
   logic [31:0] rdata = 0;
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int aw_cyc = 0, w_cyc = 0, aw_hs = 0, b_hs = 0, r_hs = 0, viol = 0;
   bit aw_ok, w_ok, pend_b, pend_r, b_drop, r_drop, pv_aw, pv_w, pv_ar;
   logic [31:0] aw_addr = 0, w_data = 0, ar_addr = 0;
   logic [3:0] w_strb = 0;

   axi4_lite_master #(.ADDR_WIDTH(32), .ALIGN(1)) dut (
      .clk(clk), .reset(reset),
      .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WRITE(AMCI_WRITE),
      .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
      .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ), .AMCI_RDATA(AMCI_RDATA),
      .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 clk = ~clk;

   // slave: ready/valid decisions made on the falling edge take effect at the next rising edge
   initial forever begin
      @(negedge clk);
      if (reset) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
         {aw_ok, w_ok, pend_b, pend_r, b_drop, r_drop, pv_aw, pv_w, pv_ar} = '0;
         {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
         continue;
      end
      if ((pv_aw && !M_AXI_AWVALID) || (pv_w && !M_AXI_WVALID) || (pv_ar && !M_AXI_ARVALID)) viol++;
      if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) viol++;
      if (M_AXI_RREADY && M_AXI_ARVALID) viol++;
      if (b_drop) begin M_AXI_BVALID = 0; b_drop = 0; end
      else if (pend_b) begin
         if (b_cnt >= b_delay) begin M_AXI_BVALID = 1; M_AXI_BRESP = bresp; pend_b = 0; end
         else b_cnt++;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_hs++; b_drop = 1; end
      if (r_drop) begin M_AXI_RVALID = 0; r_drop = 0; end
      else if (pend_r) begin
         if (r_cnt >= r_delay) begin M_AXI_RVALID = 1; M_AXI_RDATA = rdata; M_AXI_RRESP = rresp; pend_r = 0; end
         else r_cnt++;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin r_hs++; r_drop = 1; end
      M_AXI_AWREADY = 0; pv_aw = 0;
      if (M_AXI_AWVALID) begin
         aw_cyc++;
         if (aw_cnt >= aw_delay) begin
            M_AXI_AWREADY = 1; aw_addr = M_AXI_AWADDR; aw_hs++; aw_ok = 1; aw_cnt = 0;
         end else begin aw_cnt++; pv_aw = 1; end
      end
      M_AXI_WREADY = 0; pv_w = 0;
      if (M_AXI_WVALID) begin
         w_cyc++;
         if (w_cnt >= w_delay) begin
            M_AXI_WREADY = 1; w_data = M_AXI_WDATA; w_strb = M_AXI_WSTRB; w_ok = 1; w_cnt = 0;
         end else begin w_cnt++; pv_w = 1; end
      end
      if (aw_ok && w_ok) begin aw_ok = 0; w_ok = 0; pend_b = 1; b_cnt = 0; end
      M_AXI_ARREADY = 0; pv_ar = 0;
      if (M_AXI_ARVALID) begin
         if (ar_cnt >= ar_delay) begin
            M_AXI_ARREADY = 1; ar_addr = M_AXI_ARADDR; pend_r = 1; r_cnt = 0; ar_cnt = 0;
         end else begin ar_cnt++; pv_ar = 1; end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_write(input logic [31:0] a, input logic [31:0] d);
      tick();
      AMCI_WADDR = a; AMCI_WDATA = d; AMCI_WRITE = 1;
      tick();
      AMCI_WRITE = 0;
   endtask

   task automatic start_read(input logic [31:0] a);
      tick();
      AMCI_RADDR = a; AMCI_READ = 1;
      tick();
      AMCI_READ = 0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100 && !(AMCI_WIDLE && AMCI_RIDLE); n++) tick();
      checks++;
      if (!(AMCI_WIDLE && AMCI_RIDLE)) begin
         errors++;
         $display("FAIL idle_timeout: widle=%0b ridle=%0b required 1/1", AMCI_WIDLE, AMCI_RIDLE);
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
         errors++; $display("FAIL reset_handshake: got %b required 00000",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
      end
      checks++;
      if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, AMCI_RDATA, AMCI_WRESP, AMCI_RRESP} !== '0) begin
         errors++; $display("FAIL reset_regs: awaddr=%h araddr=%h wdata=%h rdata=%h wresp=%0d rresp=%0d",
            M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, AMCI_RDATA, AMCI_WRESP, AMCI_RRESP);
      end
      checks++;
      if ({AMCI_WIDLE, AMCI_RIDLE, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT} !== {2'b11, 4'hF, 6'b0}) begin
         errors++; $display("FAIL reset_const: widle=%b ridle=%b wstrb=%h prot=%b/%b required 1 1 f 0 0",
            AMCI_WIDLE, AMCI_RIDLE, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT);
      end
      reset = 0;
   endtask

   task automatic test_min_latency();
      int c0 = aw_cyc, w0 = w_cyc;
      start_write(32'h0, 32'h12345678);
      checks++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, AMCI_WIDLE} !== 4'b1100) begin
         errors++; $display("FAIL lat_edge1: awv,wv,bready,widle=%b required 1100",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, AMCI_WIDLE});
      end
      tick();
      checks++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, AMCI_WIDLE} !== 4'b0010) begin
         errors++; $display("FAIL lat_edge2: awv,wv,bready,widle=%b required 0010",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, AMCI_WIDLE});
      end
      tick();
      checks++;
      if ({AMCI_WIDLE, M_AXI_BREADY, AMCI_WRESP} !== 4'b1000) begin
         errors++; $display("FAIL lat_edge3: widle=%b bready=%b wresp=%0d required 1 0 0",
            AMCI_WIDLE, M_AXI_BREADY, AMCI_WRESP);
      end
      checks++;
      if (aw_addr !== 32'h0 || w_data !== 32'h12345678 || w_strb !== 4'hF) begin
         errors++; $display("FAIL lat_data: awaddr=%h wdata=%h wstrb=%h required 0 12345678 f",
            aw_addr, w_data, w_strb);
      end
      checks++;
      if (aw_cyc - c0 != 1 || w_cyc - w0 != 1) begin
         errors++; $display("FAIL lat_valid_cycles: aw=%0d w=%0d required 1 1", aw_cyc - c0, w_cyc - w0);
      end
   endtask

   task automatic test_aw_stall();
      int c0 = aw_cyc, w0 = w_cyc, v0 = viol;
      aw_delay = 4;
      start_write(32'h8, 32'hCAFEF00D);
      wait_idle();
      aw_delay = 0;
      checks++;
      if (aw_cyc - c0 != 5 || w_cyc - w0 != 1) begin
         errors++; $display("FAIL aw_stall_cycles: aw=%0d w=%0d required 5 1", aw_cyc - c0, w_cyc - w0);
      end
      checks++;
      if (viol != v0 || AMCI_WRESP !== 2'd0 || w_data !== 32'hCAFEF00D) begin
         errors++; $display("FAIL aw_stall_result: viol=%0d wresp=%0d wdata=%h required 0 0 cafef00d",
            viol - v0, AMCI_WRESP, w_data);
      end
   endtask

   task automatic test_resp_and_read();
      bresp = 3;
      start_write(32'h44, 32'h0BADF00D);
      wait_idle();
      bresp = 0;
      checks++;
      if (AMCI_WRESP !== 2'd3 || aw_addr !== 32'h44) begin
         errors++; $display("FAIL bresp3: wresp=%0d awaddr=%h required 3 44", AMCI_WRESP, aw_addr);
      end
      rdata = 32'hDEADBEEF; rresp = 0;
      start_read(32'h07);
      checks++;
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h04 || AMCI_RIDLE !== 1'b0) begin
         errors++; $display("FAIL read_issue: arvalid=%b araddr=%h ridle=%b required 1 4 0",
            M_AXI_ARVALID, M_AXI_ARADDR, AMCI_RIDLE);
      end
      wait_idle();
      checks++;
      if (AMCI_RDATA !== 32'hDEADBEEF || AMCI_RRESP !== 2'd0 || ar_addr !== 32'h04) begin
         errors++; $display("FAIL read_result: rdata=%h rresp=%0d araddr=%h required deadbeef 0 4",
            AMCI_RDATA, AMCI_RRESP, ar_addr);
      end
   endtask

   task automatic test_ignore_busy();
      int h0 = aw_hs;
      aw_delay = 3;
      start_write(32'h100, 32'hA5A5A5A5);
      start_write(32'h200, 32'h5A5A5A5A);
      wait_idle();
      aw_delay = 0;
      repeat (4) tick();
      checks++;
      if (aw_hs - h0 != 1 || aw_addr !== 32'h100 || w_data !== 32'hA5A5A5A5 || !AMCI_WIDLE) begin
         errors++; $display("FAIL ignore_busy: aw_count=%0d awaddr=%h wdata=%h widle=%b required 1 100 a5a5a5a5 1",
            aw_hs - h0, aw_addr, w_data, AMCI_WIDLE);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] wa [4] = '{32'h10, 32'h4B, 32'h80, 32'hFC};
      logic [31:0] wx [4] = '{32'h10, 32'h48, 32'h80, 32'hFC};
      logic [31:0] ra [4] = '{32'h21, 32'h30, 32'h3E, 32'h0};
      logic [31:0] rx [4] = '{32'h20, 32'h30, 32'h3C, 32'h0};
      int v0 = viol;
      for (int i = 0; i < 4; i++) begin
         aw_delay = $urandom_range(0, 5); w_delay = $urandom_range(0, 5); b_delay = $urandom_range(0, 4);
         ar_delay = $urandom_range(0, 5); r_delay = $urandom_range(0, 4);
         bresp = 2'(i); rresp = 2'(3 - i); rdata = 32'h1000_0001 * (i + 3);
         tick();
         AMCI_WADDR = wa[i]; AMCI_WDATA = ~rdata; AMCI_WRITE = 1;
         AMCI_RADDR = ra[i]; AMCI_READ = 1;
         tick();
         AMCI_WRITE = 0; AMCI_READ = 0;
         wait_idle();
         checks++;
         if (AMCI_WRESP !== 2'(i) || aw_addr !== wx[i] || w_data !== ~rdata) begin
            errors++; $display("FAIL sim_write[%0d]: wresp=%0d awaddr=%h wdata=%h required %0d %h %h",
               i, AMCI_WRESP, aw_addr, w_data, i, wx[i], ~rdata);
         end
         checks++;
         if (AMCI_RDATA !== rdata || AMCI_RRESP !== 2'(3 - i) || ar_addr !== rx[i]) begin
            errors++; $display("FAIL sim_read[%0d]: rdata=%h rresp=%0d araddr=%h required %h %0d %h",
               i, AMCI_RDATA, AMCI_RRESP, ar_addr, rdata, 3 - i, rx[i]);
         end
      end
      {aw_delay, w_delay, b_delay, ar_delay, r_delay} = '0;
      checks++;
      if (viol != v0) begin
         errors++; $display("FAIL protocol: violations=%0d required 0", viol - v0);
      end
   endtask

   task automatic test_reset_wait_b();
      bresp = 2;
      start_write(32'h10, 32'h1);
      wait_idle();
      checks++;
      if (AMCI_WRESP !== 2'd2) begin
         errors++; $display("FAIL pre_reset_wresp: got %0d required 2", AMCI_WRESP);
      end
      b_delay = 10;
      start_write(32'h20, 32'h2);
      for (int n = 0; n < 20 && !M_AXI_BREADY; n++) tick();
      checks++;
      if (M_AXI_BREADY !== 1'b1 || AMCI_WIDLE !== 1'b0) begin
         errors++; $display("FAIL reach_wait_b: bready=%b widle=%b required 1 0", M_AXI_BREADY, AMCI_WIDLE);
      end
      reset = 1;
      tick();
      reset = 0;
      checks++;
      if (M_AXI_BREADY !== 1'b0 || AMCI_WIDLE !== 1'b1 || AMCI_WRESP !== 2'd0 || AMCI_RDATA !== 32'h0) begin
         errors++; $display("FAIL reset_wait_b: bready=%b widle=%b wresp=%0d rdata=%h required 0 1 0 0",
            M_AXI_BREADY, AMCI_WIDLE, AMCI_WRESP, AMCI_RDATA);
      end
      b_delay = 0; bresp = 1;
      start_write(32'h30, 32'h77);
      wait_idle();
      checks++;
      if (AMCI_WRESP !== 2'd1 || aw_addr !== 32'h30 || w_data !== 32'h77) begin
         errors++; $display("FAIL after_reset_write: wresp=%0d awaddr=%h wdata=%h required 1 30 77",
            AMCI_WRESP, aw_addr, w_data);
      end
   endtask

   initial begin
      test_reset();
      test_min_latency();
      test_aw_stall();
      test_resp_and_read();
      test_ignore_busy();
      test_simultaneous();
      test_reset_wait_b();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
